// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: shared types and constants for the two-requester memory port
// arbiter.
//   arb_state_t : sequencer states (IDLE, ACCESS, RD_WAIT)
//   REQ_CPU/AUD : requester indices, also the encoding of owner/last_owner
//   mem_req_t   : one latched single-beat access (we, addr, wdata)
//   rr_pick     : round-robin choice when both requesters contend
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RD_WAIT = 2'd2
  } arb_state_t;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_AUD = 1'b1;

  // Widths of the latched access record. The arbiter's ADDR_W/DATA_W
  // default to these, and its access record is sized by them.
  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;

  typedef struct packed {
    logic                  we;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] wdata;
  } mem_req_t;

  // With both requesters contending, the one that did not own the port
  // last time goes next.
  function automatic logic rr_pick(input logic last_owner);
    return ~last_owner;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// mem_arb_pick: combinational winner select for the memory port arbiter.
// Ports:
//   req[1:0]   in  request lines, index REQ_CPU / REQ_AUD
//   urgent     in  audio FIFO below its low watermark
//   last_owner in  requester granted most recently
//   wait_cnt   in  consecutive urgent-override losses by the CPU
//   any_req    out at least one request is pending
//   winner     out selected requester (meaningful when any_req is high)
//   by_urgent  out the audio requester won through the urgent override
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int WAIT_W   = 3,
  parameter int MAX_WAIT = 4
) (
  input  logic [1:0]        req,
  input  logic              urgent,
  input  logic              last_owner,
  input  logic [WAIT_W-1:0] wait_cnt,
  output logic              any_req,
  output logic              winner,
  output logic              by_urgent
);

  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  // Priority chain: starvation guard, urgent override, round-robin, single.
  always_comb begin
    any_req   = req[REQ_CPU] | req[REQ_AUD];
    winner    = REQ_CPU;
    by_urgent = 1'b0;
    if (req[REQ_CPU] && (wait_cnt == WAIT_MAX)) begin
      winner = REQ_CPU;
    end else if (req[REQ_AUD] && urgent) begin
      winner    = REQ_AUD;
      by_urgent = 1'b1;
    end else if (req[REQ_CPU] && req[REQ_AUD]) begin
      winner = rr_pick(last_owner);
    end else if (req[REQ_AUD]) begin
      winner = REQ_AUD;
    end else begin
      winner = REQ_CPU;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-beat memory/peripheral port between the
// CPU load/store path (m0) and the audio DMA engine (m1).
// Each access is IDLE (arbitrate + latch) -> ACCESS (one issue cycle) and,
// for reads, RD_WAIT until the read data is captured for the owner.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   mN_req/we/addr/wdata          requester N access request
//   mN_gnt                        pulse in requester N's issue cycle
//   mN_rvalid/mN_rdata            read return pulse; rdata held until next
//   m1_urgent                     audio FIFO low; overrides round-robin
//   mem_addr/wdata/we/re          shared port, non-zero only in ACCESS
//   mem_rdata                     read data, RD_LAT cycles after mem_re
//   busy, owner                   sequencer not idle / current owner
// All outputs are registers. The shared port registers double as the
// latched access: they are loaded from the winner at the IDLE -> ACCESS
// edge and cleared on the way out of ACCESS.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = MEM_ADDR_W,
  parameter int DATA_W   = MEM_DATA_W,
  parameter int RD_LAT   = 1,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  input  logic              m1_urgent,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  localparam int                WAIT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);
  localparam logic [2:0]        RD_LAST  = 3'(RD_LAT - 1);

  arb_state_t        state;
  arb_state_t        next_state;
  logic              last_owner;
  logic [WAIT_W-1:0] wait_cnt;
  logic [2:0]        rd_cnt;
  logic              any_req;
  logic              winner;
  logic              by_urgent;
  logic              rd_done;
  mem_req_t          win_req;

  mem_arb_pick #(
    .WAIT_W   (WAIT_W),
    .MAX_WAIT (MAX_WAIT)
  ) u_pick (
    .req        ({m1_req, m0_req}),
    .urgent     (m1_urgent),
    .last_owner (last_owner),
    .wait_cnt   (wait_cnt),
    .any_req    (any_req),
    .winner     (winner),
    .by_urgent  (by_urgent)
  );

  // mem_rdata is only looked at in this one cycle of RD_WAIT.
  assign rd_done = (state == RD_WAIT) && (rd_cnt == RD_LAST);

  // Gather the winning requester's access attributes.
  always_comb begin
    win_req = '0;
    if (winner == REQ_AUD) begin
      win_req.we    = m1_we;
      win_req.addr  = MEM_ADDR_W'(m1_addr);
      win_req.wdata = MEM_DATA_W'(m1_wdata);
    end else begin
      win_req.we    = m0_we;
      win_req.addr  = MEM_ADDR_W'(m0_addr);
      win_req.wdata = MEM_DATA_W'(m0_wdata);
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Sequencer next-state; in ACCESS mem_we still holds the latched direction.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (any_req) begin
          next_state = ACCESS;
        end else begin
          next_state = IDLE;
        end
      end
      ACCESS: begin
        if (mem_we) begin
          next_state = IDLE;
        end else begin
          next_state = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (rd_done) begin
          next_state = IDLE;
        end else begin
          next_state = RD_WAIT;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Grant, issue on the shared port, count read latency and return data.
  always_ff @(posedge clk) begin
    if (rst) begin
      m0_gnt     <= 1'b0;
      m1_gnt     <= 1'b0;
      m0_rvalid  <= 1'b0;
      m1_rvalid  <= 1'b0;
      m0_rdata   <= '0;
      m1_rdata   <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_we     <= 1'b0;
      mem_re     <= 1'b0;
      busy       <= 1'b0;
      owner      <= REQ_CPU;
      last_owner <= REQ_AUD;
      rd_cnt     <= 3'd0;
    end else begin
      m0_gnt    <= 1'b0;
      m1_gnt    <= 1'b0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      busy      <= (next_state != IDLE);
      case (state)
        IDLE: begin
          if (any_req) begin
            owner      <= winner;
            last_owner <= winner;
            m0_gnt     <= (winner == REQ_CPU);
            m1_gnt     <= (winner == REQ_AUD);
            mem_addr   <= ADDR_W'(win_req.addr);
            mem_wdata  <= DATA_W'(win_req.wdata);
            mem_we     <= win_req.we;
            mem_re     <= ~win_req.we;
          end
        end
        ACCESS: begin
          rd_cnt <= 3'd0;
        end
        RD_WAIT: begin
          rd_cnt <= rd_cnt + 3'd1;
          if (rd_done) begin
            if (owner == REQ_AUD) begin
              m1_rdata  <= mem_rdata;
              m1_rvalid <= 1'b1;
            end else begin
              m0_rdata  <= mem_rdata;
              m0_rvalid <= 1'b1;
            end
          end
        end
        default: begin
          rd_cnt <= 3'd0;
        end
      endcase
    end
  end

  // Count urgent-override losses of a pending CPU request; only the IDLE
  // arbitration cycle can change it.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (state == IDLE) begin
      if (!m0_req) begin
        wait_cnt <= '0;
      end else if (winner == REQ_CPU) begin
        wait_cnt <= '0;
      end else if (by_urgent && (wait_cnt != WAIT_MAX)) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end else begin
        wait_cnt <= wait_cnt;
      end
    end else begin
      wait_cnt <= wait_cnt;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: instance a uses RD_LAT=1, instance b RD_LAT=3;
// both share all inputs. Expected issues and read returns are queued when
// stimulus is driven and popped when the DUT shows them.
module tb_mem_port_arbiter;

  typedef struct packed {
    logic        who;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } iss_t;

  typedef struct packed {
    logic        who;
    logic [31:0] data;
  } rd_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, m0_req, m0_we, m1_req, m1_we, m1_urgent;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, mem_rdata;

  logic        a_m0_gnt, a_m0_rvalid, a_m1_gnt, a_m1_rvalid;
  logic        a_mem_we, a_mem_re, a_busy, a_owner;
  logic [31:0] a_m0_rdata, a_m1_rdata, a_mem_addr, a_mem_wdata;
  logic        b_m0_gnt, b_m0_rvalid, b_m1_gnt, b_m1_rvalid;
  logic        b_mem_we, b_mem_re, b_busy, b_owner;
  logic [31:0] b_m0_rdata, b_m1_rdata, b_mem_addr, b_mem_wdata;
  logic [135:0] a_all, b_all;

  assign a_all = {a_m0_gnt, a_m0_rvalid, a_m0_rdata, a_m1_gnt, a_m1_rvalid, a_m1_rdata,
                  a_mem_addr, a_mem_wdata, a_mem_we, a_mem_re, a_busy, a_owner};
  assign b_all = {b_m0_gnt, b_m0_rvalid, b_m0_rdata, b_m1_gnt, b_m1_rvalid, b_m1_rdata,
                  b_mem_addr, b_mem_wdata, b_mem_we, b_mem_re, b_busy, b_owner};

  iss_t iss_q[$];
  rd_t  rd_q[$];
  int   checks = 0;
  int   failures = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(1), .MAX_WAIT(4)) dut_a (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(a_m0_gnt), .m0_rvalid(a_m0_rvalid), .m0_rdata(a_m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(a_m1_gnt), .m1_rvalid(a_m1_rvalid), .m1_rdata(a_m1_rdata),
    .m1_urgent(m1_urgent),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_we(a_mem_we), .mem_re(a_mem_re),
    .mem_rdata(mem_rdata), .busy(a_busy), .owner(a_owner)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(3), .MAX_WAIT(4)) dut_b (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(b_m0_gnt), .m0_rvalid(b_m0_rvalid), .m0_rdata(b_m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(b_m1_gnt), .m1_rvalid(b_m1_rvalid), .m1_rdata(b_m1_rdata),
    .m1_urgent(m1_urgent),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_we(b_mem_we), .mem_re(b_mem_re),
    .mem_rdata(mem_rdata), .busy(b_busy), .owner(b_owner)
  );

  task automatic test_reset();
    rst = 1'b1; m0_req = 1'b1; m1_req = 1'b1; m1_urgent = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (a_all !== 136'd0) begin failures++; $display("FAIL reset_a actual=%h required=0", a_all); end
    checks++;
    if (b_all !== 136'd0) begin failures++; $display("FAIL reset_b actual=%h required=0", b_all); end
    rst = 1'b0; m0_req = 1'b0; m1_req = 1'b0; m1_urgent = 1'b0;
    @(negedge clk);
    checks++;
    if ({a_busy, a_m0_gnt, a_m1_gnt} !== 3'b000) begin
      failures++; $display("FAIL reset_nogrant actual=%b required=000", {a_busy, a_m0_gnt, a_m1_gnt});
    end
  endtask

  task automatic test_write();
    iss_t e;
    @(negedge clk);
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h0000_0100; m0_wdata = 32'hDEAD_BEEF;
    iss_q.push_back({1'b0, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF});
    @(negedge clk);
    e = iss_q.pop_front();
    checks++;
    if ({a_owner, a_mem_we, a_mem_addr, a_mem_wdata} !== {e.who, e.we, e.addr, e.wdata}) begin
      failures++;
      $display("FAIL wr_issue actual owner=%b we=%b addr=%h wdata=%h required %b %b %h %h",
               a_owner, a_mem_we, a_mem_addr, a_mem_wdata, e.who, e.we, e.addr, e.wdata);
    end
    checks++;
    if ({a_m0_gnt, a_m1_gnt, a_mem_re, a_busy} !== 4'b1001) begin
      failures++; $display("FAIL wr_gnt actual=%b required=1001", {a_m0_gnt, a_m1_gnt, a_mem_re, a_busy});
    end
    m0_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({a_busy, a_m0_gnt, a_mem_we, a_m0_rvalid, a_m1_rvalid} !== 5'b00000) begin
      failures++;
      $display("FAIL wr_done actual=%b required=00000", {a_busy, a_m0_gnt, a_mem_we, a_m0_rvalid, a_m1_rvalid});
    end
  endtask

  task automatic test_read();
    iss_t e;
    rd_t  r;
    @(negedge clk);
    mem_rdata = 32'hBAD0_0001;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h0000_2000; m1_wdata = 32'h0;
    iss_q.push_back({1'b1, 1'b0, 32'h0000_2000, 32'h0});
    rd_q.push_back({1'b1, 32'h1234_5678});
    @(negedge clk);
    e = iss_q.pop_front();
    checks++;
    if ({a_owner, a_mem_we, a_mem_re, a_mem_addr, a_m1_gnt} !== {e.who, e.we, ~e.we, e.addr, 1'b1}) begin
      failures++;
      $display("FAIL rd_issue actual owner=%b we=%b re=%b addr=%h gnt=%b required %b %b %b %h 1",
               a_owner, a_mem_we, a_mem_re, a_mem_addr, a_m1_gnt, e.who, e.we, ~e.we, e.addr);
    end
    m1_req = 1'b0;
    @(negedge clk);
    checks++;
    if (a_m1_rvalid !== 1'b0) begin failures++; $display("FAIL rd_early actual=%b required=0", a_m1_rvalid); end
    mem_rdata = 32'h1234_5678;
    @(negedge clk);
    r = rd_q.pop_front();
    checks++;
    if ({a_m1_rvalid, a_m1_rdata} !== {1'b1, r.data}) begin
      failures++; $display("FAIL rd_data actual=%b/%h required=1/%h", a_m1_rvalid, a_m1_rdata, r.data);
    end
    checks++;
    if (a_m0_rvalid !== 1'b0) begin failures++; $display("FAIL rd_m0_quiet actual=%b required=0", a_m0_rvalid); end
    mem_rdata = 32'hBAD0_0002;
    @(negedge clk);
    checks++;
    if ({a_m1_rvalid, a_m1_rdata, a_busy} !== {1'b0, r.data, 1'b0}) begin
      failures++; $display("FAIL rd_hold actual=%b/%h/%b required=0/%h/0", a_m1_rvalid, a_m1_rdata, a_busy, r.data);
    end
  endtask

  task automatic test_round_robin();
    iss_t e;
    @(negedge clk);
    rst = 1'b1; m0_req = 1'b0; m1_req = 1'b0; m1_urgent = 1'b0;
    @(negedge clk);
    rst = 1'b0; m0_req = 1'b1; m1_req = 1'b1; m0_we = 1'b1; m1_we = 1'b1;
    m0_addr = 32'h300; m0_wdata = 32'h3; m1_addr = 32'h400; m1_wdata = 32'h4;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) iss_q.push_back({1'b0, 1'b1, 32'h300, 32'h3});
      else            iss_q.push_back({1'b1, 1'b1, 32'h400, 32'h4});
    end
    for (int c = 0; c < 60 && iss_q.size() != 0; c++) begin
      @(negedge clk);
      if (a_m0_gnt || a_m1_gnt) begin
        e = iss_q.pop_front();
        checks++;
        if ({a_m1_gnt, a_m0_gnt, a_owner, a_mem_addr, a_mem_wdata} !== {e.who, ~e.who, e.who, e.addr, e.wdata}) begin
          failures++;
          $display("FAIL rr_grant actual m1/m0=%b%b owner=%b addr=%h required owner=%b addr=%h",
                   a_m1_gnt, a_m0_gnt, a_owner, a_mem_addr, e.who, e.addr);
        end
      end
    end
    checks++;
    if (iss_q.size() != 0) begin failures++; $display("FAIL rr_timeout actual left=%0d required=0", iss_q.size()); end
    iss_q.delete();
    m0_req = 1'b0; m1_req = 1'b0;
  endtask

  task automatic test_urgent();
    iss_t e;
    @(negedge clk);
    rst = 1'b1; m0_req = 1'b0; m1_req = 1'b0;
    @(negedge clk);
    rst = 1'b0; m0_req = 1'b1; m1_req = 1'b1; m1_urgent = 1'b1; m0_we = 1'b1; m1_we = 1'b1;
    m0_addr = 32'h500; m0_wdata = 32'h5; m1_addr = 32'h600; m1_wdata = 32'h6;
    for (int i = 0; i < 10; i++) begin
      if (i % 5 == 4) iss_q.push_back({1'b0, 1'b1, 32'h500, 32'h5});
      else            iss_q.push_back({1'b1, 1'b1, 32'h600, 32'h6});
    end
    for (int c = 0; c < 60 && iss_q.size() != 0; c++) begin
      @(negedge clk);
      if (a_m0_gnt || a_m1_gnt) begin
        e = iss_q.pop_front();
        checks++;
        if ({a_m1_gnt, a_m0_gnt, a_owner, a_mem_addr} !== {e.who, ~e.who, e.who, e.addr}) begin
          failures++;
          $display("FAIL urgent_grant actual m1/m0=%b%b owner=%b addr=%h required owner=%b addr=%h",
                   a_m1_gnt, a_m0_gnt, a_owner, a_mem_addr, e.who, e.addr);
        end
      end
    end
    checks++;
    if (iss_q.size() != 0) begin failures++; $display("FAIL urgent_timeout actual left=%0d required=0", iss_q.size()); end
    iss_q.delete();
    m0_req = 1'b0; m1_req = 1'b0; m1_urgent = 1'b0;
  endtask

  task automatic test_reset_rd_wait();
    logic seen;
    logic granted;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h40; mem_rdata = 32'hCAFE_0040;
    @(negedge clk);
    checks++;
    if ({b_m0_gnt, b_mem_re, b_mem_addr} !== {1'b1, 1'b1, 32'h40}) begin
      failures++; $display("FAIL rst_rd_issue actual=%b%b/%h required=11/00000040", b_m0_gnt, b_mem_re, b_mem_addr);
    end
    m0_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (b_all !== 136'd0) begin failures++; $display("FAIL rst_rd_clear actual=%h required=0", b_all); end
    rst = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (b_m0_rvalid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin failures++; $display("FAIL rst_rd_rvalid actual=1 required=0"); end
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h80; m1_wdata = 32'h8080;
    granted = 1'b0;
    for (int c = 0; c < 4 && !granted; c++) begin
      @(negedge clk);
      if (b_m1_gnt) begin
        granted = 1'b1;
        checks++;
        if ({b_owner, b_mem_we, b_mem_addr, b_mem_wdata} !== {1'b1, 1'b1, 32'h80, 32'h8080}) begin
          failures++;
          $display("FAIL rst_next_issue actual %b %b %h %h required 1 1 00000080 00008080",
                   b_owner, b_mem_we, b_mem_addr, b_mem_wdata);
        end
      end
    end
    checks++;
    if (!granted) begin failures++; $display("FAIL rst_next_timeout actual=no_grant required=grant"); end
    m1_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    iss_t          e;
    rd_t           r;
    int            t_iss[2];
    int            n_iss = 0;
    int            n_rd = 0;
    logic [31:0]   pdata[2];
    pdata[0] = 32'hA5A5_0010;
    pdata[1] = 32'hA5A5_0014;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10; m0_wdata = 32'h0; m1_req = 1'b0;
    mem_rdata = 32'hBAD0_0003;
    iss_q.push_back({1'b0, 1'b0, 32'h10, 32'h0});
    iss_q.push_back({1'b0, 1'b0, 32'h14, 32'h0});
    rd_q.push_back({1'b0, pdata[0]});
    rd_q.push_back({1'b0, pdata[1]});
    for (int c = 1; c <= 30 && n_rd < 2; c++) begin
      @(negedge clk);
      if (b_mem_re) begin
        if (n_iss < 2) begin
          e = iss_q.pop_front();
          checks++;
          if ({b_owner, b_m0_gnt, b_mem_addr} !== {e.who, 1'b1, e.addr}) begin
            failures++; $display("FAIL b2b_issue actual owner=%b gnt=%b addr=%h required %b 1 %h",
                                 b_owner, b_m0_gnt, b_mem_addr, e.who, e.addr);
          end
          t_iss[n_iss] = c;
          if (n_iss == 0) m0_addr = 32'h14;
          else            m0_req = 1'b0;
        end else begin
          failures++; checks++; $display("FAIL b2b_extra_issue actual addr=%h required=none", b_mem_addr);
        end
        n_iss++;
      end
      if (b_m0_rvalid) begin
        if (n_rd < n_iss) begin
          r = rd_q.pop_front();
          checks++;
          if (b_m0_rdata !== r.data) begin
            failures++; $display("FAIL b2b_rdata actual=%h required=%h", b_m0_rdata, r.data);
          end
          checks++;
          if (c != t_iss[n_rd] + 4) begin
            failures++; $display("FAIL b2b_rvalid_cycle actual=%0d required=%0d", c, t_iss[n_rd] + 4);
          end
        end else begin
          failures++; checks++; $display("FAIL b2b_extra_rvalid actual=%h required=none", b_m0_rdata);
        end
        n_rd++;
      end
      mem_rdata = 32'hBAD0_0004;
      for (int k = 0; k < n_iss && k < 2; k++) begin
        if (c == t_iss[k] + 3) mem_rdata = pdata[k];
      end
    end
    checks++;
    if (n_iss != 2 || (t_iss[1] - t_iss[0]) != 5) begin
      failures++; $display("FAIL b2b_spacing actual issues=%0d gap=%0d required issues=2 gap=5",
                           n_iss, (n_iss == 2) ? (t_iss[1] - t_iss[0]) : -1);
    end
    checks++;
    if (n_rd != 2) begin failures++; $display("FAIL b2b_timeout actual returns=%0d required=2", n_rd); end
    m0_req = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0;
    m1_urgent = 1'b0; mem_rdata = 32'h0;
    test_reset();
    test_write();
    test_read();
    test_round_robin();
    test_urgent();
    test_reset_rd_wait();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the CPU core's single external memory/peripheral port (addr, wdata, we, rdata) between two requesters.
- Requester m0 is the CPU load/store path; requester m1 is the audio DMA engine.
- Sequences each access: arbitrates, issues one single-beat access, waits the fixed read latency, then returns read data to the owner.
- Round-robin fairness, an urgent override for the audio FIFO, and a starvation guard for the CPU.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- RD_LAT, 1, cycles from the issue cycle to valid mem_rdata; legal range 1..7
- MAX_WAIT, 4, consecutive urgent-override losses by m0 before m0 is forced to win

Ports:
- clk  in  1  clock, all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- m0_req  in  1  CPU request; held stable until m0_gnt
- m0_we  in  1  1 = write, 0 = read
- m0_addr  in  ADDR_W  CPU address
- m0_wdata  in  DATA_W  CPU write data
- m0_gnt  out  1  one-cycle pulse in m0's issue cycle
- m0_rvalid  out  1  one-cycle read-data-valid pulse
- m0_rdata  out  DATA_W  read data, held until m0's next read returns
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata  same as m0, for audio DMA
- m1_urgent  in  1  audio FIFO below its low watermark
- mem_addr  out  ADDR_W  shared port address
- mem_wdata  out  DATA_W  shared port write data
- mem_we  out  1  write strobe
- mem_re  out  1  read strobe
- mem_rdata  in  DATA_W  read data, valid RD_LAT cycles after the mem_re cycle
- busy  out  1  state != IDLE
- owner  out  1  requester currently owning the port; valid while busy

Behaviour:
Reset:
- State IDLE; all outputs 0.
- last_owner = 1, so m0 wins first on a tie.
- wait_cnt = 0; rd_cnt = 0.

States:
- IDLE -> ACCESS when any req is high. The winner's we/addr/wdata are latched, owner is set to the winner, and the state moves to ACCESS.
- ACCESS, exactly one cycle:
  - mem_addr and mem_wdata driven from latched values; mem_we = latched we; mem_re = !latched we.
  - Owner's gnt = 1 this cycle only.
  - Write: go to IDLE.
  - Read: go to RD_WAIT with rd_cnt = 0.
- RD_WAIT:
  - rd_cnt increments each cycle.
  - When rd_cnt == RD_LAT-1, mem_rdata is captured into owner's rdata, owner's rvalid pulses on the next cycle, and the state moves to IDLE.
  - Issue at cycle t gives rvalid and rdata visible at cycle t+RD_LAT+1.
- Outside ACCESS: mem_we = mem_re = 0; mem_addr = mem_wdata = 0.

Throughput:
- Write: 2 cycles per transaction (IDLE arbitration + ACCESS).
- Read: RD_LAT+2 cycles per transaction.
- No pipelining; at most one outstanding access.

Arbitration, evaluated only in IDLE, highest priority first:
1. m0_req and wait_cnt == MAX_WAIT: m0 wins.
2. m1_req and m1_urgent: m1 wins.
3. Both requesting: the requester != last_owner wins (round-robin).
4. Single requester: that requester wins.

Arbitration bookkeeping:
- last_owner is updated at every grant.
- wait_cnt increments (saturating at MAX_WAIT) when m1 wins by rule 2 while m0_req is high.
- wait_cnt clears whenever m0 is granted, or when m0_req is low in IDLE.

Boundary conditions:
- Request dropped before gnt: protocol violation; the latched values are still issued.
- Both requesters high in the same cycle as rst: reset wins; no grant.
- rst during RD_WAIT: the read is abandoned; no rvalid; rdata registers cleared.
- A requester may reassert req in the cycle after its gnt. It is arbitrated at the next IDLE.
- mem_rdata is ignored in all states except the capture cycle.

Decomposition:
- Package mem_arb_pkg:
  - typedef enum logic [1:0] {IDLE, ACCESS, RD_WAIT} arb_state_t
  - localparam REQ_CPU = 0, REQ_AUD = 1
  - struct mem_req_t {we, addr, wdata}
- Optional sub-module: mem_arb_pick. Combinational winner select from req, urgent, last_owner and wait_cnt, so it can be unit-tested separately.
- Everything else lives in mem_port_arbiter.

Test Plan:
1. Reset, then m0 write addr 0x100 data 0xDEAD_BEEF -> issue cycle: mem_we=1, mem_addr=0x100, m0_gnt=1; no rvalid; busy low after 2 cycles.
2. m1 read 0x2000, mem_rdata=0x1234_5678 at RD_LAT=1 -> m1_rvalid pulses at issue+2 with m1_rdata=0x1234_5678; m0_rvalid stays 0.
3. m0 and m1 both request continuously, m1_urgent=0 -> grants alternate m0, m1, m0, m1 starting with m0 after reset.
4. m0 and m1 request continuously, m1_urgent=1, MAX_WAIT=4 -> m1 wins 4 consecutive arbitrations, 5th goes to m0, then m1 resumes.
5. m0 read issued, rst asserted 1 cycle into RD_WAIT -> no m0_rvalid ever; all outputs 0 the cycle after rst; next request granted normally.
6. RD_LAT=3, back-to-back m0 reads 0x10 and 0x14 -> second mem_re exactly 5 cycles after the first; each rvalid carries the data presented at issue+3.
